// File: rtl/rv32_pkg.sv
// Shared rv32 core types and constants used by the fetch stage.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch only ever addresses whole words.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output fetch_entry_t           head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     mem_q [DEPTH];

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// rv32 fetch stage: PC and request bookkeeping in front of the fetch FIFO feeding decode.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  redirect_target;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] in_use;
  logic             run_q;
  logic             gnt, drop, push, pop, fifo_valid;
  fetch_entry_t     push_entry, head;

  // Requests are only issued when every outstanding response already owns a FIFO slot.
  assign in_use    = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
  assign imem_req  = run_q && (in_use < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign gnt             = imem_req && imem_gnt;
  assign drop            = imem_rvalid && (discard_q != '0);
  assign push            = imem_rvalid && !drop && !redirect_valid;
  assign pop             = fifo_valid && instr_ready;
  assign redirect_target = word_align(redirect_pc);
  assign push_entry      = '{pc: resp_pc_q, instr: imem_rdata};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(imem_rvalid);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      discard_d  = outstanding_d;
    end else begin
      if (gnt)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) resp_pc_d  = resp_pc_q + XLEN'(4);
      if (drop) discard_d  = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      // Holds imem_req low until the first clock edge after reset release.
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .count_o    (fifo_count),
    .valid_o    (fifo_valid),
    .head_o     (head)
  );

  assign instr_valid = fifo_valid;
  assign instr       = fifo_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = fifo_valid ? head.pc : '0;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the rv32 core, directly upstream of instruction decode. Holds the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words with their PCs in a small FIFO, and presents them to decode through a valid/ready handshake. A redirect from execute (branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, fetch FIFO entries (power of 2, ≥2); also the maximum number of outstanding requests

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  request valid
- imem_addr  out  32  word address, bits [1:0] always 0
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req)
- imem_rvalid  in  1  read data valid; responses in order, ≥1 cycle after gnt
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- instr_valid  out  1  FIFO head valid
- instr  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- instr_pc  out  32  head PC; 0 when empty
- instr_ready  in  1  decode accepts head

## Operation
- State: fetch_pc, resp_pc, FIFO count, outstanding (0..DEPTH), discard (0..DEPTH).
- imem_req = (count + outstanding < DEPTH); imem_addr = fetch_pc. Both derived from registered state only; no combinational path from instr_ready, redirect_valid or imem_gnt.
- Once asserted, imem_req and imem_addr are held until gnt or redirect.
- Grant: fetch_pc += 4 (wraps at 2^32); outstanding += 1.
- Response (rvalid): outstanding -= 1. If discard > 0: discard -= 1, word dropped. Else push {resp_pc, rdata}; resp_pc += 4.
- Pop when instr_valid && instr_ready.
- Redirect: fetch_pc, resp_pc <= {redirect_pc[31:2],2'b00}; FIFO emptied (a pop in the same cycle is still a handshake, but nothing is pushed); a response in the same cycle is dropped; discard <= outstanding + gnt - rvalid (counting this cycle's grant and response); outstanding continues counting normally.
- Redirect has priority over all same-cycle pushes and PC updates.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- A push and a pop in the same cycle with FIFO full is not possible: the request gating guarantees space for every outstanding response.

## Timing
- Reset (async assert, sync release internal): imem_req=0 while rst_n low, instr_valid=0, instr=NOP, instr_pc=0, all counters 0, fetch_pc=resp_pc=RESET_PC.
- First cycle after release: imem_req=1, imem_addr=RESET_PC.
- rvalid in cycle N -> instr_valid in cycle N+1 (registered FIFO, no bypass).
- Redirect in cycle N -> imem_addr=redirect_pc in N+1; earliest redirected instruction at decode is N+3 with a 1-cycle memory.
- With a 1-cycle-latency memory and decode always ready, sustains 1 instruction/cycle for DEPTH ≥ 4.
- Reset mid-operation: all state is cleared and in-flight responses are forgotten. Instruction memory shares rst_n and drops its pending responses.

## Structure
- rv32_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, push, pop, flush, count, head. instr_fetch holds the PC, counters and handshake logic.

## Test plan
- Reset, then imem grants every cycle with 1-cycle rvalid, data = addr, decode always ready -> instr_pc = 0,4,8,… one per cycle, instr == instr_pc; no bubbles after the first.
- Decode stalls (instr_ready=0) for 10 cycles -> at most DEPTH requests outstanding plus buffered; imem_req drops; on release, PCs resume in order with no loss or duplication.
- Random gnt/rvalid latency of 1–3 cycles -> output PC sequence strictly +4, and the instr/PC pairing is preserved.
- With 3 outstanding requests, redirect_pc=32'h100 -> 3 responses dropped, FIFO empty next cycle, first delivered instr_pc=32'h100.
- Redirect in the same cycle as a gnt and an rvalid -> discard = outstanding + 1 - 1; no stale word reaches decode. redirect_pc=32'h103 -> fetch at 32'h100.
- Assert rst_n low mid-stream -> instr_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC.
